// File: rtl/moving_average_filter.sv
// moving_average_filter
//
// Averages the most recent 2^LOG2_DEPTH unsigned samples and presents the
// floor of the mean on out_data, with a one-cycle dr pulse per result.
//
//   MODE 0 : sliding window. After the window first fills, every accepted
//            sample produces a result.
//   MODE 1 : block average. One result per DEPTH accepted samples. The
//            accumulator and fill count restart after each result.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   en         in   sample strobe; in_data is taken on edges where en=1
//   in_data    in   [WIDTH-1:0] unsigned sample
//   flush      in   synchronous clear of the window state; wins over en
//   out_data   out  [WIDTH-1:0] last average, held between results
//   dr         out  one-cycle pulse on the cycle out_data is updated
//   fill_count out  [LOG2_DEPTH:0] valid samples in the current window/block

module moving_average_filter #(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned LOG2_DEPTH = 2,
   parameter int unsigned MODE       = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic [WIDTH-1:0]      in_data,
   input  logic                  flush,
   output logic [WIDTH-1:0]      out_data,
   output logic                  dr,
   output logic [LOG2_DEPTH:0]   fill_count
);

   localparam int unsigned DEPTH = 1 << LOG2_DEPTH;
   localparam int unsigned SUM_W = WIDTH + LOG2_DEPTH;
   localparam int unsigned CNT_W = LOG2_DEPTH + 1;

   localparam logic [LOG2_DEPTH:0] FILL_FULL = CNT_W'(DEPTH);
   localparam logic [LOG2_DEPTH:0] FILL_LAST = CNT_W'(DEPTH - 1);

   // Accumulator is wide enough for DEPTH full-scale samples, so it never wraps.
   logic [SUM_W-1:0]      sum_q, sum_d;
   logic [SUM_W-1:0]      sum_next;
   logic [LOG2_DEPTH:0]   fill_q, fill_d;
   logic [WIDTH-1:0]      out_q, out_d;
   logic                  dr_q, dr_d;

   // Sample leaving the window when a new one is written (always 0 in MODE 1).
   logic [WIDTH-1:0]      oldest;

   // Only accepted, non-flushed samples touch the window state.
   logic                  accept;
   assign accept = en && !flush;

   //------------------------------------------------------------------------
   // Sample buffer and write pointer, built only for the sliding window.
   //------------------------------------------------------------------------
   if (MODE == 0) begin : g_window
      logic [WIDTH-1:0]      buf_q [DEPTH];
      logic [LOG2_DEPTH-1:0] wp_q;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            wp_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
               buf_q[i] <= '0;
            end
         end else if (flush) begin
            // Zeroing the buffer keeps the sum equal to the sum of its entries.
            wp_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
               buf_q[i] <= '0;
            end
         end else if (en) begin
            buf_q[wp_q] <= in_data;
            wp_q        <= wp_q + LOG2_DEPTH'(1);
         end
      end

      assign oldest = buf_q[wp_q];
   end else begin : g_block
      assign oldest = '0;
   end

   // Subtracting the evicted entry cannot underflow: it is part of sum_q.
   assign sum_next = sum_q + SUM_W'(in_data) - SUM_W'(oldest);

   //------------------------------------------------------------------------
   // Next-state logic
   //------------------------------------------------------------------------
   always_comb begin
      sum_d  = sum_q;
      fill_d = fill_q;
      out_d  = out_q;
      dr_d   = 1'b0;

      if (flush) begin
         sum_d  = '0;
         fill_d = '0;
      end else if (accept) begin
         if (MODE == 0) begin
            sum_d = sum_next;
            if (fill_q != FILL_FULL) begin
               fill_d = fill_q + CNT_W'(1);
            end
            // Window is full once this sample lands.
            if (fill_q >= FILL_LAST) begin
               out_d = sum_next[SUM_W-1:LOG2_DEPTH];
               dr_d  = 1'b1;
            end
         end else begin
            if (fill_q == FILL_LAST) begin
               out_d  = sum_next[SUM_W-1:LOG2_DEPTH];
               dr_d   = 1'b1;
               sum_d  = '0;
               fill_d = '0;
            end else begin
               sum_d  = sum_next;
               fill_d = fill_q + CNT_W'(1);
            end
         end
      end
   end

   //------------------------------------------------------------------------
   // State registers
   //------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum_q  <= '0;
         fill_q <= '0;
         out_q  <= '0;
         dr_q   <= 1'b0;
      end else begin
         sum_q  <= sum_d;
         fill_q <= fill_d;
         out_q  <= out_d;
         dr_q   <= dr_d;
      end
   end

   assign out_data   = out_q;
   assign dr         = dr_q;
   assign fill_count = fill_q;

endmodule

// File: tb/tb_moving_average_filter.sv
// Bench for moving_average_filter: one sliding-window instance and one
// block-average instance share the same stimulus. A behavioural model built
// on sample queues predicts each step; predictions go through a scoreboard
// queue and are checked one cycle later.

module tb_moving_average_filter;

   localparam int unsigned WIDTH      = 8;
   localparam int unsigned LOG2_DEPTH = 2;
   localparam int unsigned DEPTH      = 1 << LOG2_DEPTH;

   logic                clk;
   logic                rst;
   logic                en;
   logic [WIDTH-1:0]    in_data;
   logic                flush;
   logic [WIDTH-1:0]    out0, out1;
   logic                dr0, dr1;
   logic [LOG2_DEPTH:0] fill0, fill1;

   moving_average_filter #(
      .WIDTH      (WIDTH),
      .LOG2_DEPTH (LOG2_DEPTH),
      .MODE       (0)
   ) u_dut0 (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .in_data    (in_data),
      .flush      (flush),
      .out_data   (out0),
      .dr         (dr0),
      .fill_count (fill0)
   );

   moving_average_filter #(
      .WIDTH      (WIDTH),
      .LOG2_DEPTH (LOG2_DEPTH),
      .MODE       (1)
   ) u_dut1 (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .in_data    (in_data),
      .flush      (flush),
      .out_data   (out1),
      .dr         (dr1),
      .fill_count (fill1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec;
   int n_err;

   typedef struct {
      string tag;
      int    dr0;
      int    out0;
      int    fill0;
      int    dr1;
      int    out1;
      int    fill1;
   } exp_t;

   exp_t sb[$];

   // Reference model state
   int win[$];
   int blk[$];
   int m_out0;
   int m_out1;

   task automatic chk(input string tag, input logic [31:0] got, input int want);
      n_vec++;
      assert (got === want) else begin
         n_err++;
         $error("FAIL %s: got %0d expected %0d", tag, got, want);
      end
   endtask

   task automatic model_reset();
      win.delete();
      blk.delete();
      m_out0 = 0;
      m_out1 = 0;
   endtask

   task automatic model_step(input bit e, input int d, input bit f, input string tag,
                             output exp_t x);
      int s;
      x.tag = tag;
      x.dr0 = 0;
      x.dr1 = 0;
      if (f) begin
         win.delete();
         blk.delete();
      end else if (e) begin
         win.push_back(d);
         if (win.size() > DEPTH) void'(win.pop_front());
         if (win.size() == DEPTH) begin
            s = 0;
            foreach (win[i]) s += win[i];
            m_out0 = s / DEPTH;
            x.dr0  = 1;
         end
         blk.push_back(d);
         if (blk.size() == DEPTH) begin
            s = 0;
            foreach (blk[i]) s += blk[i];
            m_out1 = s / DEPTH;
            x.dr1  = 1;
            blk.delete();
         end
      end
      x.out0  = m_out0;
      x.out1  = m_out1;
      x.fill0 = win.size();
      x.fill1 = blk.size();
   endtask

   // Drive one cycle of stimulus, then check both instances just after the edge.
   task automatic apply(input bit e, input int d, input bit f, input string tag);
      exp_t x;
      en      = e;
      in_data = WIDTH'(d);
      flush   = f;
      model_step(e, d, f, tag, x);
      sb.push_back(x);
      @(posedge clk);
      #1;
      x = sb.pop_front();
      chk({x.tag, "_dr0"},   32'(dr0),   x.dr0);
      chk({x.tag, "_out0"},  32'(out0),  x.out0);
      chk({x.tag, "_fill0"}, 32'(fill0), x.fill0);
      chk({x.tag, "_dr1"},   32'(dr1),   x.dr1);
      chk({x.tag, "_out1"},  32'(out1),  x.out1);
      chk({x.tag, "_fill1"}, 32'(fill1), x.fill1);
      en    = 1'b0;
      flush = 1'b0;
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_out0"},  32'(out0),  0);
      chk({tag, "_dr0"},   32'(dr0),   0);
      chk({tag, "_fill0"}, 32'(fill0), 0);
      chk({tag, "_out1"},  32'(out1),  0);
      chk({tag, "_dr1"},   32'(dr1),   0);
      chk({tag, "_fill1"}, 32'(fill1), 0);
   endtask

   initial begin
      n_vec   = 0;
      n_err   = 0;
      rst     = 1'b1;
      en      = 1'b0;
      flush   = 1'b0;
      in_data = '0;
      model_reset();

      repeat (2) @(posedge clk);
      #1;
      chk_reset_state("rst_init");
      rst = 1'b0;

      // Sliding-window fill and first results
      apply(1, 4,  0, "t1_s4");
      apply(1, 8,  0, "t1_s8");
      apply(1, 12, 0, "t1_s12");
      apply(1, 16, 0, "t1_s16");
      chk("t1_avg10", 32'(out0), 10);
      apply(1, 20, 0, "t1_s20");
      chk("t1_avg14", 32'(out0), 14);
      chk("t1_fill4", 32'(fill0), 4);

      // Full-scale samples, then truncating average
      apply(0, 0, 1, "t2_flush");
      for (int i = 0; i < 4; i++) apply(1, 255, 0, "t2_max");
      chk("t2_avg255", 32'(out0), 255);
      apply(1, 0, 0, "t2_zero");
      chk("t2_avg191", 32'(out0), 191);

      // Block averaging over 1..8
      apply(0, 0, 1, "t3_flush");
      for (int i = 1; i <= 8; i++) begin
         apply(1, i, 0, "t3_blk");
         if (i == 4) chk("t3_avg2", 32'(out1), 2);
      end
      chk("t3_avg6", 32'(out1), 6);

      // Refill to out_data=14, then asynchronous reset between edges
      apply(0, 0, 1, "t5_flush");
      apply(1, 4,  0, "t5_s4");
      apply(1, 8,  0, "t5_s8");
      apply(1, 12, 0, "t5_s12");
      apply(1, 16, 0, "t5_s16");
      apply(1, 20, 0, "t5_s20");
      chk("t5_pre14", 32'(out0), 14);
      #3;
      rst = 1'b1;
      #1;
      chk_reset_state("t5_async");
      model_reset();
      @(negedge clk);
      rst = 1'b0;

      // Post-reset: three samples give no result, flush drops its sample
      apply(1, 100, 0, "t4_s100");
      apply(1, 100, 0, "t4_s100");
      apply(1, 100, 0, "t4_s100");
      apply(1, 50,  1, "t4_flush_en");
      chk("t4_hold0", 32'(out0), 0);
      for (int i = 0; i < 4; i++) apply(1, 8, 0, "t4_s8");
      chk("t4_avg8", 32'(out0), 8);

      // Gapped strobes: idle cycles carry junk data that must be ignored
      apply(0, 0, 1, "t6_flush");
      for (int k = 1; k <= 4; k++) begin
         apply(1, 2 * k, 0, "t6_samp");
         if (k < 4) begin
            for (int j = 0; j < 3; j++) apply(0, int'($urandom_range(255, 0)), 0, "t6_idle");
         end
      end
      chk("t6_avg5", 32'(out0), 5);
      apply(0, 0, 0, "t6_after");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
